// File: rtl/gpio_ctrl_debounce.sv
// gpio_ctrl_debounce
//   Per-bank input glitch filter. A pin's filtered level only moves after the
//   synchronised input has disagreed with it on threshold+1 consecutive sample
//   ticks. Sample ticks come from one programmable prescaler shared by every
//   pin in the bank. Pins with their enable bit cleared bypass the filter and
//   become a plain one-cycle register stage.
//
//   Handshake: none. Inputs are sampled every clock and outputs are valid every
//   clock. gpio_filt_changed[i] is high for exactly the cycle in which
//   gpio_filt_data[i] shows its new value.
module gpio_ctrl_debounce #(
   parameter int WIDTH          = 32,
   parameter int CNT_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          gpio_in_data,
   input  logic [WIDTH-1:0]          debounce_enable,
   input  logic [PRESCALE_WIDTH-1:0] debounce_prescale,
   input  logic [CNT_WIDTH-1:0]      debounce_threshold,
   output logic [WIDTH-1:0]          gpio_filt_data,
   output logic [WIDTH-1:0]          gpio_filt_changed
);

   logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
   logic                      tick;

   logic [CNT_WIDTH-1:0]      cnt_q [WIDTH];
   logic [CNT_WIDTH-1:0]      cnt_d [WIDTH];
   logic [WIDTH-1:0]          filt_q, filt_d;
   logic [WIDTH-1:0]          chg_q,  chg_d;

   // Prescaler: the >= compare means lowering the prescale below the current
   // count produces a tick immediately instead of waiting for a wrap.
   always_comb begin
      tick   = (pcnt_q >= debounce_prescale);
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
   end

   // Per-pin stability counters and next filtered level.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!debounce_enable[i]) begin
            // Bypass: follow the input one clock late, drop any partial count.
            filt_d[i] = gpio_in_data[i];
            cnt_d[i]  = '0;
         end else if (gpio_in_data[i] == filt_q[i]) begin
            // Input agrees with the filtered level: any run in progress is lost.
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] >= debounce_threshold) begin
               // Enough consecutive disagreeing ticks; also covers a threshold
               // lowered below a count already in flight.
               filt_d[i] = gpio_in_data[i];
               cnt_d[i]  = '0;
            end else if (cnt_q[i] != {CNT_WIDTH{1'b1}}) begin
               cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
      chg_d = filt_d ^ filt_q;
   end

   // State registers; reset discards all filter progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
         filt_q <= '0;
         chg_q  <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         pcnt_q <= pcnt_d;
         filt_q <= filt_d;
         chg_q  <= chg_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign gpio_filt_data    = filt_q;
   assign gpio_filt_changed = chg_q;

endmodule

// File: tb/tb_gpio_ctrl_debounce.sv
// Directed bench for gpio_ctrl_debounce: reset, glitch rejection, prescaled
// sampling, bypass, threshold drop and a simultaneous mixed-enable change.
module tb_gpio_ctrl_debounce;

   logic        clk;
   logic        rst_n;
   logic [31:0] gpio_in_data;
   logic [31:0] debounce_enable;
   logic [15:0] debounce_prescale;
   logic [7:0]  debounce_threshold;
   logic [31:0] gpio_filt_data;
   logic [31:0] gpio_filt_changed;

   int n_vec;
   int n_err;
   logic [63:0] exp_q[$];

   gpio_ctrl_debounce dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .gpio_in_data      (gpio_in_data),
      .debounce_enable   (debounce_enable),
      .debounce_prescale (debounce_prescale),
      .debounce_threshold(debounce_threshold),
      .gpio_filt_data    (gpio_filt_data),
      .gpio_filt_changed (gpio_filt_changed)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse reset with the given config; returns 1 time unit after release.
   task automatic do_reset(input logic [15:0] pre, input logic [7:0] thr, input logic [31:0] en);
      step(1);
      rst_n              = 1'b0;
      gpio_in_data       = '0;
      debounce_prescale  = pre;
      debounce_threshold = thr;
      debounce_enable    = en;
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] en;
      logic [31:0] c;
      logic [63:0] e;
      n_vec = 0;
      n_err = 0;

      // ---- 1. Reset -------------------------------------------------------
      rst_n              = 1'b0;
      gpio_in_data       = 32'hFFFF_FFFF;
      debounce_enable    = 32'hFFFF_FFFF;
      debounce_prescale  = 16'd0;
      debounce_threshold = 8'd3;
      #1;
      check("rst_async_filt", gpio_filt_data, 32'h0);
      check("rst_async_chg", gpio_filt_changed, 32'h0);
      step(1);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         check("rst_release_wait", gpio_filt_data, 32'h0);
      end
      step(1);
      check("rst_release_rise", gpio_filt_data, 32'hFFFF_FFFF);
      check("rst_release_chg", gpio_filt_changed, 32'hFFFF_FFFF);
      step(1);
      check("rst_release_chg_off", gpio_filt_changed, 32'h0);
      // Asynchronous assertion away from the clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_midcycle_filt", gpio_filt_data, 32'h0);

      // ---- 2. Glitch reject ----------------------------------------------
      do_reset(16'd0, 8'd3, 32'hFFFF_FFFF);
      gpio_in_data = 32'h1;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         check("glitch_3clk_filt", gpio_filt_data, 32'h0);
      end
      gpio_in_data = 32'h0;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         check("glitch_after_filt", gpio_filt_data, 32'h0);
         check("glitch_after_chg", gpio_filt_changed, 32'h0);
      end
      gpio_in_data = 32'h1;
      step(3);
      check("pulse4_pre", gpio_filt_data, 32'h0);
      step(1);
      check("pulse4_rise", gpio_filt_data, 32'h1);
      check("pulse4_chg", gpio_filt_changed, 32'h1);
      gpio_in_data = 32'h0;

      // ---- 3. Prescale ---------------------------------------------------
      // After release, ticks fall on edges 10, 20, 30, ...
      do_reset(16'd9, 8'd1, 32'hFFFF_FFFF);
      step(10);
      gpio_in_data = 32'h20;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         check("pre_rise_filt", gpio_filt_data, (k == 20) ? 32'h20 : 32'h0);
      end
      check("pre_rise_chg", gpio_filt_changed, 32'h20);

      do_reset(16'd9, 8'd1, 32'hFFFF_FFFF);
      step(10);
      gpio_in_data = 32'h20;
      step(15);                       // edge 25: one tick (edge 20) counted
      gpio_in_data = 32'h0;
      step(1);                        // edge 26: glitch clears the count
      gpio_in_data = 32'h20;
      for (int k = 27; k <= 40; k++) begin
         step(1);
         check("pre_glitch_filt", gpio_filt_data, (k == 40) ? 32'h20 : 32'h0);
      end

      // ---- 4. Bypass -----------------------------------------------------
      do_reset(16'd0, 8'd255, 32'h7FFF_FFFF);
      for (int k = 0; k < 8; k++) begin
         d = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
         gpio_in_data = d;
         step(1);
         check("bypass_filt", gpio_filt_data, d & 32'h8000_0000);
         check("bypass_chg", gpio_filt_changed, 32'h8000_0000);
      end
      gpio_in_data = 32'h0;

      // ---- 5. Threshold drop ---------------------------------------------
      do_reset(16'd0, 8'd200, 32'hFFFF_FFFF);
      gpio_in_data = 32'h80;
      step(50);
      check("thr_hold_filt", gpio_filt_data, 32'h0);
      debounce_threshold = 8'd10;
      step(1);
      check("thr_drop_filt", gpio_filt_data, 32'h80);
      check("thr_drop_chg", gpio_filt_changed, 32'h80);
      step(1);
      check("thr_drop_chg_off", gpio_filt_changed, 32'h0);

      // ---- 6. Simultaneous change, mixed enables (scoreboard) ------------
      en = 32'hA5C3_0F96;
      do_reset(16'd0, 8'd3, en);
      // Phase A: all pins 0 -> 1.
      exp_q.push_back({~en, ~en});
      exp_q.push_back({~en, 32'h0});
      exp_q.push_back({~en, 32'h0});
      exp_q.push_back({32'hFFFF_FFFF, en});
      exp_q.push_back({32'hFFFF_FFFF, 32'h0});
      // Phase B: pins cleared in d fall from 1 to 0.
      d = 32'h0F0F_F0F0;
      c = ~d;
      exp_q.push_back({~(c & ~en), c & ~en});
      exp_q.push_back({~(c & ~en), 32'h0});
      exp_q.push_back({~(c & ~en), 32'h0});
      exp_q.push_back({d, c & en});
      exp_q.push_back({d, 32'h0});

      gpio_in_data = 32'hFFFF_FFFF;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) gpio_in_data = d;
         step(1);
         e = exp_q.pop_front();
         check("simul_filt", gpio_filt_data, e[63:32]);
         check("simul_chg", gpio_filt_changed, e[31:0]);
      end

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
